// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C time target.
// Holds the bit-level FSM state encoding, register map indices, default
// device address / ID byte, and the register-map read mux used both for
// the live snapshot load and for reads from the held snapshot.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    IGNORE
  } state_t;

  localparam logic [2:0] REG_SEC     = 3'd0;
  localparam logic [2:0] REG_MIN     = 3'd1;
  localparam logic [2:0] REG_HOUR    = 3'd2;
  localparam logic [2:0] REG_TEMP_HI = 3'd3;
  localparam logic [2:0] REG_TEMP_LO = 3'd4;
  localparam logic [2:0] REG_ID      = 3'd5;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h42;
  localparam logic [7:0] ID_BYTE_DEF  = 8'hC1;

  // Register map: indices 6 and 7 read as zero.
  function automatic logic [7:0] reg_byte(input logic [2:0]  idx,
                                          input logic [5:0]  sec,
                                          input logic [5:0]  mn,
                                          input logic [5:0]  hr,
                                          input logic [15:0] temp,
                                          input logic [7:0]  id);
    case (idx)
      REG_SEC:     reg_byte = {2'b00, sec};
      REG_MIN:     reg_byte = {2'b00, mn};
      REG_HOUR:    reg_byte = {2'b00, hr};
      REG_TEMP_HI: reg_byte = temp[15:8];
      REG_TEMP_LO: reg_byte = temp[7:0];
      REG_ID:      reg_byte = id;
      default:     reg_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer and bus-condition detector.
// Ports:
//   clk, rst          system clock, async active-high reset
//   scl_i, sda_i      raw bus levels
//   sda_s             synchronized SDA level
//   scl_rise/scl_fall one-clk pulses on synchronized SCL edges
//   start_det         SDA falling while SCL held high
//   stop_det          SDA rising while SCL held high
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sh, sda_sh;
  logic scl_s, scl_d, sda_d;

  // Flops reset to the idle-bus level (both lines high) so leaving reset
  // on a quiet bus produces no spurious events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sh <= '1;
      sda_sh <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_sh <= {scl_sh[SYNC_STAGES-2:0], scl_i};
      sda_sh <= {sda_sh[SYNC_STAGES-2:0], sda_i};
      scl_d  <= scl_sh[SYNC_STAGES-1];
      sda_d  <= sda_sh[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sh[SYNC_STAGES-1];
  assign sda_s     = sda_sh[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_d;
  assign scl_fall  = ~scl_s &  scl_d;
  // SCL must be high on both samples so an SDA change coinciding with an
  // SCL edge is never mistaken for START/STOP.
  assign start_det = scl_s & scl_d &  sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_time_target.sv
// I2C target exposing the clock's time and temperature as an 8-entry
// register file with an auto-incrementing pointer.
// Ports:
//   clk, rst                    system clock (>= 20x SCL), async active-high reset
//   scl_i, sda_i                bus levels; sda_oe=1 pulls SDA low
//   sec_d, min_d, hour_d, temp_d live sources, snapshotted at read-address match
//   wr_en, wr_addr, wr_data     one-clk strobe for host writes to registers 0..2
//   busy                        high from address match to STOP/NACK/mismatch
module i2c_time_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEF,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_BYTE     = ID_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [5:0]  sec_d,
  input  logic [5:0]  min_d,
  input  logic [5:0]  hour_d,
  input  logic [15:0] temp_d,
  output logic        wr_en,
  output logic [2:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t      state, state_d;
  logic [2:0]  cnt, ptr, ptr_inc;
  logic [7:0]  shift, byte_in;
  logic        rw, oe_d;
  logic        last_rise, ack_done, addr_hit;
  logic [5:0]  snap_sec, snap_min, snap_hour;
  logic [15:0] snap_temp;

  assign byte_in   = {shift[6:0], sda_s};
  assign last_rise = scl_rise && (cnt == 3'd7);
  // ACK slots count 0 -> 1 on the fall that starts the slot; the second
  // fall (cnt==1) ends it. RACK reuses this after a controller ACK.
  assign ack_done  = scl_fall && (cnt == 3'd1);
  assign addr_hit  = (byte_in[7:1] == DEV_ADDR);
  assign ptr_inc   = ptr + 3'd1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state; START/STOP override everything
  always_comb begin
    state_d = state;
    if (start_det)     state_d = ADDR;
    else if (stop_det) state_d = IDLE;
    else begin
      case (state)
        ADDR:      if (last_rise) state_d = addr_hit ? ADDR_ACK : IGNORE;
        ADDR_ACK:  if (ack_done)  state_d = rw ? RDATA : PTR;
        PTR:       if (last_rise) state_d = PTR_ACK;
        PTR_ACK:   if (ack_done)  state_d = WDATA;
        WDATA:     if (last_rise) state_d = WDATA_ACK;
        WDATA_ACK: if (ack_done)  state_d = WDATA;
        RDATA:     if (scl_fall && cnt == 3'd7) state_d = RACK;
        RACK: begin
          if (scl_rise && sda_s) state_d = IGNORE;
          else if (ack_done)     state_d = RDATA;
        end
        default: state_d = state;
      endcase
    end
  end

  // Next SDA drive level; only moves on SCL falls so SDA is stable while
  // SCL is high.
  always_comb begin
    oe_d = sda_oe;
    if (start_det || stop_det) oe_d = 1'b0;
    else begin
      case (state)
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt == 3'd0) oe_d = 1'b1;
            else             oe_d = (state == ADDR_ACK && rw) ? ~shift[7] : 1'b0;
          end
        end
        RDATA:   if (scl_fall) oe_d = (cnt == 3'd7) ? 1'b0 : ~shift[6];
        RACK:    if (ack_done) oe_d = ~shift[7];
        default: oe_d = 1'b0;
      endcase
    end
  end

  // Datapath: shifter, bit counter, pointer, snapshot, strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= 3'd0;
      wr_data   <= 8'h00;
      cnt       <= 3'd0;
      ptr       <= 3'd0;
      shift     <= 8'h00;
      rw        <= 1'b0;
      snap_sec  <= 6'd0;
      snap_min  <= 6'd0;
      snap_hour <= 6'd0;
      snap_temp <= 16'h0000;
    end else begin
      sda_oe <= oe_d;
      wr_en  <= 1'b0;
      if (start_det) begin
        cnt <= 3'd0;
      end else if (stop_det) begin
        cnt  <= 3'd0;
        busy <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shift <= byte_in;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              busy <= addr_hit;
              if (addr_hit) begin
                rw <= byte_in[0];
                if (byte_in[0]) begin
                  snap_sec  <= sec_d;
                  snap_min  <= min_d;
                  snap_hour <= hour_d;
                  snap_temp <= temp_d;
                  shift     <= reg_byte(ptr, sec_d, min_d, hour_d, temp_d, ID_BYTE);
                end
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK:
            if (scl_fall) cnt <= (cnt == 3'd0) ? 3'd1 : 3'd0;
          PTR: if (scl_rise) begin
            shift <= byte_in;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) ptr <= byte_in[2:0];
          end
          WDATA: if (scl_rise) begin
            shift <= byte_in;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (ptr <= 3'd2) begin
                wr_en   <= 1'b1;
                wr_addr <= ptr;
                wr_data <= byte_in;
              end
              ptr <= ptr_inc;
            end
          end
          RDATA: if (scl_fall) begin
            cnt   <= cnt + 3'd1;
            shift <= {shift[6:0], 1'b0};
          end
          RACK: begin
            if (scl_rise) begin
              ptr <= ptr_inc;
              if (sda_s) busy <= 1'b0;
              else begin
                cnt   <= 3'd1;
                shift <= reg_byte(ptr_inc, snap_sec, snap_min, snap_hour, snap_temp, ID_BYTE);
              end
            end else if (ack_done) begin
              cnt <= 3'd0;
            end
          end
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_time_target.sv
// Self-checking bench: bit-banged I2C controller, transaction-level model
// of the register file / pointer, and a per-cycle monitor on the strobes
// and SDA drive timing.
module tb_i2c_time_target;

  localparam int Q = 6;  // quarter SCL period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_scl = 1'b1, m_sda = 1'b1;
  logic        sda_bus;
  logic        sda_oe, wr_en, busy;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [5:0]  sec_d = 6'd0, min_d = 6'd0, hour_d = 6'd0;
  logic [15:0] temp_d = 16'h0000;

  int checks = 0, errors = 0;
  int ptr_m = 0;
  bit m_active = 0;
  int snap [8];
  logic [10:0] exp_q [$];
  logic [10:0] obs_q [$];

  assign sda_bus = m_sda & ~sda_oe;
  always #5 clk = ~clk;

  i2c_time_target dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (m_scl),
    .sda_i   (sda_bus),
    .sda_oe  (sda_oe),
    .sec_d   (sec_d),
    .min_d   (min_d),
    .hour_d  (hour_d),
    .temp_d  (temp_d),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle monitor: every strobe must match the model's queue and be
  // one clk wide; SDA drive may only change while SCL is low.
  initial begin
    logic prev_en, prev_oe;
    logic [10:0] e;
    prev_en = 1'b0;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wr_en) begin
          obs_q.push_back({wr_addr, wr_data});
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr_unexpected got=%0h want=none", {wr_addr, wr_data});
          end else begin
            e = exp_q.pop_front();
            chk("wr_strobe", {wr_addr, wr_data}, e);
          end
          chk("wr_single", prev_en, 0);
        end
        if (sda_oe !== prev_oe) chk("oe_change_scl_low", m_scl, 0);
      end
      prev_en = wr_en;
      prev_oe = sda_oe;
    end
  end

  // ---- bus primitives ----
  task automatic bit_io(input bit b, output bit s);
    m_sda = b;  tick(Q);
    m_scl = 1;  tick(Q);
    s = sda_bus; tick(Q);
    m_scl = 0;  tick(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1; tick(Q);
    m_scl = 1; tick(Q);
    m_sda = 0; tick(Q);
    m_scl = 0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 0; tick(Q);
    m_scl = 1; tick(Q);
    m_sda = 1; tick(Q);
    m_active = 0;
    chk("busy_stop", busy, 0);
    chk("oe_stop", sda_oe, 0);
  endtask

  task automatic tx_byte(input logic [7:0] d, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) bit_io(d[i], s);
    bit_io(1'b1, s);
    ack = ~s;
  endtask

  task automatic rx_byte(input bit mack, output logic [7:0] d);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, s);
      d[i] = s;
    end
    bit_io(~mack, s);
  endtask

  // ---- model-aware transaction steps ----
  task automatic take_snapshot();
    snap[0] = sec_d;
    snap[1] = min_d;
    snap[2] = hour_d;
    snap[3] = temp_d / 256;
    snap[4] = temp_d % 256;
    snap[5] = 8'hC1;
    snap[6] = 0;
    snap[7] = 0;
  endtask

  task automatic addr_phase(input logic [6:0] a, input bit rw, output bit hit);
    bit ack;
    i2c_start();
    if (rw) take_snapshot();
    tx_byte({a, rw}, ack);
    hit = (a == 7'h42);
    m_active = hit;
    chk("addr_ack", ack, hit);
    chk("busy_addr", busy, hit);
  endtask

  task automatic ptr_phase(input logic [7:0] p);
    bit ack;
    tx_byte(p, ack);
    chk("ptr_ack", ack, m_active);
    if (m_active) ptr_m = p % 8;
  endtask

  task automatic wdata(input logic [7:0] d);
    bit ack;
    if (m_active && ptr_m <= 2) exp_q.push_back({3'(ptr_m), d});
    tx_byte(d, ack);
    chk("wdata_ack", ack, m_active);
    if (m_active) ptr_m = (ptr_m + 1) % 8;
    chk("wr_pending", exp_q.size(), 0);
  endtask

  task automatic rdata(input bit mack, output logic [7:0] got);
    rx_byte(mack, got);
    chk("rdata", got, snap[ptr_m]);
    ptr_m = (ptr_m + 1) % 8;
    if (!mack) begin
      m_active = 0;
      chk("busy_nack", busy, 0);
      chk("oe_nack", sda_oe, 0);
    end
  endtask

  task automatic read_n(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      rdata(i != n - 1, b);
      sec_d  = 6'($urandom_range(0, 59));
      temp_d = 16'($urandom);
    end
  endtask

  initial begin
    logic [7:0] b;
    bit hit;
    int kind, n;
    logic [6:0] a;

    // reset state
    rst = 1;
    tick(3);
    chk("rst_oe", sda_oe, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    tick(4);

    // write pointer 0, repeated START, read three bytes
    sec_d = 6'd12; min_d = 6'd34; hour_d = 6'd5; temp_d = 16'h1234;
    addr_phase(7'h42, 0, hit);
    ptr_phase(8'h00);
    addr_phase(7'h42, 1, hit);
    rdata(1, b); chk("lit_sec", b, 8'h0C);
    rdata(1, b); chk("lit_min", b, 8'h22);
    rdata(0, b); chk("lit_hour", b, 8'h05);
    i2c_stop();

    // two writes from pointer 1
    obs_q.delete();
    addr_phase(7'h42, 0, hit);
    ptr_phase(8'h01);
    wdata(8'h2D);
    wdata(8'h11);
    i2c_stop();
    chk("lit_wr_count", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("lit_wr0", obs_q[0], 11'h12D);
      chk("lit_wr1", obs_q[1], 11'h211);
    end

    // wrong address: no ACK, no strobes; then a normal read
    obs_q.delete();
    addr_phase(7'h43, 0, hit);
    ptr_phase(8'h00);
    wdata(8'h55);
    i2c_stop();
    chk("lit_nomatch_wr", obs_q.size(), 0);
    addr_phase(7'h42, 1, hit);
    rdata(0, b);
    i2c_stop();

    // pointer 7 wraps to 0; snapshot holds across live changes
    addr_phase(7'h42, 0, hit);
    ptr_phase(8'hF7);
    addr_phase(7'h42, 1, hit);
    rdata(1, b); chk("lit_reg7", b, 8'h00);
    sec_d = 6'd33; temp_d = 16'hBEEF;
    rdata(0, b); chk("lit_wrap_snap", b, 8'h0C);
    i2c_stop();

    // pointer 3, NACK after first byte, next read resumes at 4
    temp_d = 16'hA5C3;
    addr_phase(7'h42, 0, hit);
    ptr_phase(8'h03);
    i2c_stop();
    addr_phase(7'h42, 1, hit);
    rdata(0, b); chk("lit_temp_hi", b, 8'hA5);
    i2c_stop();
    addr_phase(7'h42, 1, hit);
    rdata(0, b); chk("lit_temp_lo", b, 8'hC3);
    i2c_stop();

    // reset while driving a 0 bit
    sec_d = 6'd12;
    addr_phase(7'h42, 0, hit);
    ptr_phase(8'h00);
    i2c_stop();
    addr_phase(7'h42, 1, hit);
    chk("oe_drive0", sda_oe, 1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst_async_oe", sda_oe, 0);
    chk("rst_async_busy", busy, 0);
    tick(2);
    rst = 0;
    ptr_m = 0;
    m_active = 0;
    tick(2);
    i2c_stop();
    sec_d = 6'd47;
    addr_phase(7'h42, 1, hit);
    rdata(0, b); chk("lit_after_rst", b, 8'h2F);
    i2c_stop();

    // randomized transactions against the model
    for (int t = 0; t < 24; t++) begin
      kind   = $urandom_range(0, 2);
      a      = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127)) : 7'h42;
      sec_d  = 6'($urandom_range(0, 59));
      min_d  = 6'($urandom_range(0, 59));
      hour_d = 6'($urandom_range(0, 23));
      temp_d = 16'($urandom);
      n      = $urandom_range(1, 4);
      case (kind)
        0: begin
          addr_phase(a, 0, hit);
          ptr_phase(8'($urandom));
          for (int i = 0; i < n; i++) wdata(8'($urandom));
        end
        1: begin
          addr_phase(a, 1, hit);
          if (hit) read_n(n);
        end
        default: begin
          addr_phase(a, 0, hit);
          ptr_phase(8'($urandom));
          addr_phase(a, 1, hit);
          if (hit) read_n(n);
        end
      endcase
      i2c_stop();
    end

    tick(10);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_time_target.md
Name: i2c_time_target

Overview:
- I2C target (responder) at the far end of the two-wire bus from the clock's I2C controller.
- Exposes current time and the latest temperature reading as a read-only/writable register file to an external I2C controller (host PC bridge, second board).
- Host writes to the time registers produce one-cycle write strobes toward the time-keeping logic.
- Purely sequential: synchronizers, START/STOP detection, bit-level FSM, shift register, auto-incrementing register pointer.

Parameters:
- DEV_ADDR, 7'h42, 7-bit target address matched on the bus.
- SYNC_STAGES, 2, flip-flop stages on scl_i/sda_i (min 2).
- ID_BYTE, 8'hC1, constant returned at register 5.

Ports:
- clk  in  1  system clock; must be >= 20x SCL frequency.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- scl_i  in  1  bus SCL level (target never stretches SCL).
- sda_i  in  1  bus SDA level.
- sda_oe  out  1  1 = pull SDA low (open-drain), 0 = release.
- sec_d  in  6  current seconds 0-59.
- min_d  in  6  current minutes 0-59.
- hour_d  in  6  current hours 0-23.
- temp_d  in  16  latest temperature word.
- wr_en  out  1  one-cycle write strobe.
- wr_addr  out  3  register written (0..2 only).
- wr_data  out  8  byte written.
- busy  out  1  1 from address match until STOP/NACK/mismatch.

Behaviour:
- Reset: sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, pointer=0, FSM=IDLE. Reset mid-transfer releases SDA within the same cycle (async).
- Inputs pass SYNC_STAGES flops, then a 1-cycle-delayed copy feeds edge detection. All decisions use synchronized values only.
- START: synced SDA falls while synced SCL high. STOP: SDA rises while SCL high. Both are honoured in any state. START (including repeated) -> ADDR with bit count 0; STOP -> IDLE. Neither changes the pointer.
- Data sampled on SCL rising edge, MSB first. sda_oe changes only on SCL falling edge detection (never while SCL high).
- Register map:
  - 0 sec, 1 min, 2 hour (zero-extended to 8 bits).
  - 3 temp_d[15:8], 4 temp_d[7:0].
  - 5 ID_BYTE.
  - 6 and 7 read 8'h00.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
  - ADDR: after 8 bits, addr[7:1]==DEV_ADDR -> ADDR_ACK and busy=1. Mismatch -> IGNORE, no ACK, busy=0.
  - ADDR_ACK: drive sda_oe=1 from the falling edge after bit 8 to the falling edge after bit 9.
    - R/W=0 -> PTR.
    - R/W=1 -> snapshot all six source bytes in one clk at the match, load shift register with snapshot[pointer], then RDATA.
  - PTR: 8 bits received; pointer <= byte[2:0] (upper bits ignored); ACK; -> WDATA.
  - WDATA: 8 bits received. If pointer<=2, pulse wr_en for exactly one clk with wr_addr=pointer and wr_data=byte, no later than 2 clks after the 8th rising edge. Pointers 3..7 are read-only and produce no strobe, but are still ACKed. Then pointer wraps mod 8 (7->0), ACK, loop WDATA.
  - RDATA: sda_oe = ~shift[7], updated on each falling edge. After 8 bits release SDA -> RACK.
  - RACK: sample SDA on rising edge.
    - ACK (0): pointer++, reload from snapshot (not live inputs), -> RDATA.
    - NACK: pointer++, sda_oe=0, busy=0, -> IGNORE.
  - IGNORE: sda_oe=0; wait for START/STOP.
- No value range checks on writes. The time keeper owns clamping.
- Simultaneous START and rising-SCL sample in one clk: START wins.

Decomposition:
- Shared package i2c_pkg: FSM state enum, register index constants (REG_SEC..REG_ID), ID_BYTE default.
- One sub-module, i2c_line_sync: synchronizer plus edge/START/STOP detector. Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- Write 0x42<<1|0, ptr 0x00, then repeated START, read 3 bytes with sec=12, min=34, hour=5 -> ACKs present; bytes 0x0C, 0x22, 0x05; sda_oe=0 after STOP.
- Write ptr 0x01 then data 0x2D, 0x11 -> wr_en pulses twice: (addr 1, data 0x2D) then (addr 2, data 0x11); each exactly one clk wide.
- Address 0x43 -> no ACK (sda_oe stays 0 through bit 9), busy=0, no wr_en; following correct transaction works.
- Ptr 0x07, read 2 bytes, temp_d changes between bytes -> returns 0x00 then byte from reg 0 (wrap); snapshot stays unchanged during the transaction.
- Read at ptr 3 with master NACK after first byte -> returns temp_d[15:8]; target releases SDA on NACK; next START restarts at pointer 4.
- rst asserted mid-RDATA while driving a 0 -> sda_oe=0 immediately; pointer=0; next read returns sec.
